// File: rtl/alarm_pkg.sv
// Shared state encoding and field widths for the alarm controller and its helpers.
package alarm_pkg;

    localparam int unsigned HR_W   = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned SNZ_W  = 9;
    localparam int unsigned RCNT_W = 8;
    localparam int unsigned USED_W = 3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StRinging = 2'd2,
        StSnooze  = 2'd3
    } state_e;

endpackage

// File: rtl/alarm_controller_sec_down_timer.sv
// Loadable seconds down-counter; expire flags the tick that takes the count from 1 to 0.
module sec_down_timer #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         expire
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // Combinational so the owner can change state on the same edge the count hits zero.
    assign expire = tick && (count == W'(1));

endmodule

// File: rtl/alarm_controller.sv
// Alarm FSM: compares time of day against the alarm setting, rings, snoozes and times out.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_S       = 300,
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned MAX_SNOOZE     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1hz,
    input  logic [HR_W-1:0]  cur_hr,
    input  logic [MIN_W-1:0] cur_min,
    input  logic [SEC_W-1:0] cur_sec,
    input  logic [HR_W-1:0]  alarm_hr,
    input  logic [MIN_W-1:0] alarm_min,
    input  logic             alarm_en,
    input  logic             snooze_btn,
    input  logic             stop_btn,
    output logic             ring,
    output logic             snoozing,
    output logic [1:0]       state_o,
    output logic [SNZ_W-1:0] snooze_left
);

    localparam logic [SNZ_W-1:0]  SnoozeLoad = SNZ_W'(SNOOZE_S);
    localparam logic [RCNT_W-1:0] RingLast   = RCNT_W'(RING_TIMEOUT_S - 1);
    localparam logic [USED_W-1:0] MaxUsed    = USED_W'(MAX_SNOOZE);

    state_e              state_q, state_d;
    logic [RCNT_W-1:0]   ring_cnt_q, ring_cnt_d;
    logic [USED_W-1:0]   used_q, used_d;
    logic                match, match_d, trigger;
    logic                snz_load, snz_clear, snz_tick, snz_expire;

    assign match   = (cur_hr == alarm_hr) && (cur_min == alarm_min) && (cur_sec == '0);
    assign trigger = match && !match_d;
    assign snz_tick = tick_1hz && (state_q == StSnooze);

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        used_d     = used_q;
        snz_load   = 1'b0;
        snz_clear  = 1'b0;
        if (!alarm_en) begin
            state_d    = StIdle;
            ring_cnt_d = '0;
            used_d     = '0;
            snz_clear  = 1'b1;
        end else begin
            case (state_q)
                StIdle: state_d = StArmed;
                StArmed: begin
                    if (trigger) begin
                        state_d    = StRinging;
                        ring_cnt_d = '0;
                    end
                end
                StRinging: begin
                    // A refused snooze falls through so the timeout keeps running.
                    if (stop_btn) begin
                        state_d = StArmed;
                        used_d  = '0;
                    end else if (snooze_btn && (used_q < MaxUsed)) begin
                        state_d  = StSnooze;
                        snz_load = 1'b1;
                        used_d   = used_q + USED_W'(1);
                    end else if (tick_1hz) begin
                        if (ring_cnt_q == RingLast) begin
                            state_d = StArmed;
                            used_d  = '0;
                        end else begin
                            ring_cnt_d = ring_cnt_q + RCNT_W'(1);
                        end
                    end
                end
                StSnooze: begin
                    if (stop_btn) begin
                        state_d   = StArmed;
                        used_d    = '0;
                        snz_clear = 1'b1;
                    end else if (snz_expire) begin
                        state_d    = StRinging;
                        ring_cnt_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            ring_cnt_q <= '0;
            used_q     <= '0;
            match_d    <= 1'b0;
            ring       <= 1'b0;
            snoozing   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            used_q     <= used_d;
            match_d    <= match;
            ring       <= (state_d == StRinging);
            snoozing   <= (state_d == StSnooze);
        end
    end

    assign state_o = state_q;

    sec_down_timer #(
        .W (SNZ_W)
    ) u_snooze_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (snz_clear),
        .load     (snz_load),
        .load_val (SnoozeLoad),
        .tick     (snz_tick),
        .count    (snooze_left),
        .expire   (snz_expire)
    );

endmodule
